video_timing_monitor: RTL and testbench

// - Parametrised, mode-selectable camera timing monitor. It sits between the

---
 rtl/video_timing_monitor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_monitor.sv
// Camera hsync/vsync timing monitor: row/frame/line/fps/byte-rate measurement with a selectable display word.
// Define VIDEO_TIMING_MONITOR_BCD_EN to publish packed BCD through a sequential double-dabble engine.
module video_timing_monitor #(
  parameter int unsigned REF_CLK = 200_000_000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        valid_byte_in,
  input  logic [1:0]  mode_in,
  input  logic        clear_in,
  output logic [31:0] display_out,
  output logic        stable_out,
  output logic        tick_out
);

  localparam int unsigned TICK_W = $clog2(REF_CLK + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [TICK_W-1:0] tick_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  tick_t       tick_cnt_q, tick_cnt_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  cnt_t        row_cnt_q, row_cnt_d;
  cnt_t        frame_cnt_q, frame_cnt_d;
  cnt_t        line_cnt_q, line_cnt_d;
  cnt_t        fps_cnt_q, fps_cnt_d;
  cnt_t        bps_cnt_q, bps_cnt_d;
  cnt_t        rowlen_q, rowlen_d;
  cnt_t        prev_rowlen_q, prev_rowlen_d;
  cnt_t        framelen_q, framelen_d;
  cnt_t        bps_q, bps_d;
  cnt_t        lines_new;
  logic [15:0] lines_q, lines_d;
  logic [15:0] fps_q, fps_d;
  logic        stable_q, stable_d;
  logic [31:0] display_q;
  logic        tick, hfall, vfall;

  assign tick  = (tick_cnt_q == tick_t'(REF_CLK));
  assign hfall = valid_byte_in & hs_prev_q & ~hsync_in;
  assign vfall = valid_byte_in & vs_prev_q & ~vsync_in;

  always_comb begin
    tick_cnt_d    = tick ? tick_t'(1) : tick_cnt_q + tick_t'(1);
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    row_cnt_d     = row_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    line_cnt_d    = line_cnt_q;
    fps_cnt_d     = fps_cnt_q;
    bps_cnt_d     = bps_cnt_q;
    rowlen_d      = rowlen_q;
    prev_rowlen_d = prev_rowlen_q;
    framelen_d    = framelen_q;
    lines_d       = lines_q;
    fps_d         = fps_q;
    bps_d         = bps_q;
    stable_d      = stable_q;
    lines_new     = hfall ? sat_inc(line_cnt_q) : line_cnt_q;

    if (valid_byte_in) begin
      hs_prev_d = hsync_in;
      vs_prev_d = vsync_in;
    end

    // The sync-edge byte closes the current measurement and is not counted in the next one
    if (hfall) begin
      rowlen_d      = row_cnt_q;
      prev_rowlen_d = rowlen_q;
      row_cnt_d     = '0;
    end else if (valid_byte_in) begin
      row_cnt_d = sat_inc(row_cnt_q);
    end

    if (vfall) begin
      framelen_d  = frame_cnt_q;
      frame_cnt_d = '0;
    end else if (valid_byte_in) begin
      frame_cnt_d = sat_inc(frame_cnt_q);
    end

    if (vfall) begin
      lines_d    = lines_new[15:0];
      line_cnt_d = '0;
    end else if (hfall) begin
      line_cnt_d = sat_inc(line_cnt_q);
    end

    // An event coinciding with the tick belongs to the second that starts now
    if (tick) begin
      fps_d     = fps_cnt_q[15:0];
      fps_cnt_d = vfall ? cnt_t'(1) : '0;
      bps_d     = bps_cnt_q;
      bps_cnt_d = valid_byte_in ? cnt_t'(1) : '0;
    end else begin
      if (vfall)         fps_cnt_d = sat_inc(fps_cnt_q);
      if (valid_byte_in) bps_cnt_d = sat_inc(bps_cnt_q);
    end

    if (vfall) begin
      stable_d = (rowlen_d == prev_rowlen_d) && (frame_cnt_q == framelen_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      tick_cnt_q    <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      row_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      line_cnt_q    <= '0;
      fps_cnt_q     <= '0;
      bps_cnt_q     <= '0;
      rowlen_q      <= '0;
      prev_rowlen_q <= '0;
      framelen_q    <= '0;
      lines_q       <= '0;
      fps_q         <= '0;
      bps_q         <= '0;
      stable_q      <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      row_cnt_q     <= row_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      line_cnt_q    <= line_cnt_d;
      fps_cnt_q     <= fps_cnt_d;
      bps_cnt_q     <= bps_cnt_d;
      rowlen_q      <= rowlen_d;
      prev_rowlen_q <= prev_rowlen_d;
      framelen_q    <= framelen_d;
      lines_q       <= lines_d;
      fps_q         <= fps_d;
      bps_q         <= bps_d;
      stable_q      <= stable_d;
    end
  end

`ifdef VIDEO_TIMING_MONITOR_BCD_EN

  localparam int unsigned SH_W = $clog2(CNT_W + 1);

  typedef enum logic {BCD_LOAD, BCD_SHIFT} bcd_state_e;

  bcd_state_e      bcd_state_q, bcd_state_d;
  logic [SH_W-1:0] shift_cnt_q, shift_cnt_d;
  cnt_t            bin_hi_q, bin_hi_d;
  cnt_t            bin_lo_q, bin_lo_d;
  logic [31:0]     digits_q, digits_d, digits_adj;
  logic [31:0]     display_d;
  logic [1:0]      snap_mode_q, snap_mode_d;
  logic            split_q, split_d;
  logic            done_q, done_d;
  logic [15:0]     half_hi, half_lo;
  logic [31:0]     full_val;

  always_comb begin
    half_hi  = (mode_in == 2'd0) ? fps_q : lines_q;
    half_lo  = rowlen_q[15:0];
    full_val = (mode_in == 2'd1) ? 32'(framelen_q) : 32'(bps_q);
    if (half_hi > 16'd9999)          half_hi  = 16'd9999;
    if (half_lo > 16'd9999)          half_lo  = 16'd9999;
    if (full_val > 32'd99_999_999)   full_val = 32'd99_999_999;
  end

  always_comb begin
    digits_adj = digits_q;
    for (int i = 0; i < 8; i++) begin
      if (digits_adj[4*i +: 4] >= 4'd5) digits_adj[4*i +: 4] = digits_adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bcd_state_d = bcd_state_q;
    shift_cnt_d = shift_cnt_q;
    bin_hi_d    = bin_hi_q;
    bin_lo_d    = bin_lo_q;
    digits_d    = digits_q;
    snap_mode_d = snap_mode_q;
    split_d     = split_q;
    done_d      = done_q;
    display_d   = display_q;
    case (bcd_state_q)
      BCD_LOAD: begin
        if (done_q && (mode_in == snap_mode_q)) display_d = digits_q;
        split_d     = ~mode_in[0];
        snap_mode_d = mode_in;
        bin_hi_d    = mode_in[0] ? '0 : cnt_t'(half_hi);
        bin_lo_d    = mode_in[0] ? cnt_t'(full_val) : cnt_t'(half_lo);
        digits_d    = '0;
        shift_cnt_d = SH_W'(CNT_W);
        done_d      = 1'b0;
        bcd_state_d = BCD_SHIFT;
      end
      BCD_SHIFT: begin
        // A mode change abandons the conversion so a stale mode is never published
        if (mode_in != snap_mode_q) begin
          bcd_state_d = BCD_LOAD;
        end else begin
          digits_d    = {digits_adj[30:16], split_q ? bin_hi_q[CNT_W-1] : digits_adj[15],
                         digits_adj[14:0], bin_lo_q[CNT_W-1]};
          bin_hi_d    = bin_hi_q << 1;
          bin_lo_d    = bin_lo_q << 1;
          shift_cnt_d = shift_cnt_q - SH_W'(1);
          if (shift_cnt_q == SH_W'(1)) begin
            done_d      = 1'b1;
            bcd_state_d = BCD_LOAD;
          end
        end
      end
      default: bcd_state_d = BCD_LOAD;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      bcd_state_q <= BCD_LOAD;
      shift_cnt_q <= '0;
      bin_hi_q    <= '0;
      bin_lo_q    <= '0;
      digits_q    <= '0;
      snap_mode_q <= '0;
      split_q     <= 1'b0;
      done_q      <= 1'b0;
      display_q   <= '0;
    end else begin
      bcd_state_q <= bcd_state_d;
      shift_cnt_q <= shift_cnt_d;
      bin_hi_q    <= bin_hi_d;
      bin_lo_q    <= bin_lo_d;
      digits_q    <= digits_d;
      snap_mode_q <= snap_mode_d;
      split_q     <= split_d;
      done_q      <= done_d;
      display_q   <= display_d;
    end
  end

`else

  logic [31:0] display_d;

  always_comb begin
    case (mode_in)
      2'd0:    display_d = {fps_q, rowlen_q[15:0]};
      2'd1:    display_d = 32'(framelen_q);
      2'd2:    display_d = {lines_q, rowlen_q[15:0]};
      default: display_d = 32'(bps_q);
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) display_q <= '0;
    else                    display_q <= display_d;
  end

`endif

  assign display_out = display_q;
  assign stable_out  = stable_q;
  assign tick_out    = tick;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Bench for video_timing_monitor: frame-level reference model, randomized row lengths and byte gaps.
module tb_video_timing_monitor;

  logic        clk_in;
  logic        rst_in, hsync_in, vsync_in, valid_byte_in, clear_in;
  logic [1:0]  mode_in;
  logic [31:0] d32, d16;
  logic        s32, s16, t32, t16;

  int n_tests, n_fail;
  int since_clr, gap_max;
  int bytes_sent, frames_sent, last_row, prev_row, last_flen;
  int exp_rowlen, exp_lines, exp_flen;
  int fps_first, bytes_first, nsat, exp_sat16;
  bit exp_stable;

  video_timing_monitor #(.REF_CLK(1000), .CNT_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .valid_byte_in(valid_byte_in), .mode_in(mode_in), .clear_in(clear_in),
    .display_out(d32), .stable_out(s32), .tick_out(t32));

  video_timing_monitor #(.REF_CLK(1000), .CNT_W(16)) dut16 (
    .clk_in(clk_in), .rst_in(rst_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .valid_byte_in(valid_byte_in), .mode_in(mode_in), .clear_in(clear_in),
    .display_out(d16), .stable_out(s16), .tick_out(t16));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    since_clr++;
  endtask

  task automatic idle(input int n);
    valid_byte_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic model_zero();
    since_clr = 0; bytes_sent = 0; frames_sent = 0;
    last_row = 0; prev_row = 0; last_flen = 0;
    exp_rowlen = 0; exp_lines = 0; exp_flen = 0; exp_stable = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; clear_in = 1'b0; valid_byte_in = 1'b0;
    step(); step();
    rst_in = 1'b0;
    model_zero();
  endtask

  task automatic do_clear();
    clear_in = 1'b1; valid_byte_in = 1'b0;
    step();
    clear_in = 1'b0;
    model_zero();
  endtask

  // Gap cycles carry junk sync levels that must be ignored
  task automatic send_byte(input logic hs, input logic vs);
    repeat ($urandom_range(0, gap_max)) begin
      valid_byte_in = 1'b0;
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      step();
    end
    valid_byte_in = 1'b1; hsync_in = hs; vsync_in = vs;
    step();
    valid_byte_in = 1'b0;
    bytes_sent++;
  endtask

  // n rows alternating a/b bytes; rows end on an hsync-low byte, the last one also vsync-low
  task automatic send_frame(input int n, input int a, input int b);
    int flen;
    flen = 0;
    for (int r = 0; r < n; r++) begin
      int len;
      len = (r % 2 == 0) ? a : b;
      repeat (len) send_byte(1'b1, 1'b1);
      send_byte(1'b0, (r < n - 1));
      prev_row = last_row;
      last_row = len;
      flen += len;
    end
    flen += n - 1;
    exp_stable  = (last_row == prev_row) && (flen == last_flen);
    last_flen   = flen;
    exp_flen    = flen;
    exp_rowlen  = last_row;
    exp_lines   = n;
    frames_sent++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; gap_max = 0;
    rst_in = 1'b1; clear_in = 1'b0; valid_byte_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; mode_in = 2'd2;

    do_reset();
    check("reset_display", d32, 32'd0);
    check("reset_stable", {31'd0, s32}, 32'd0);
    check("reset_tick", {31'd0, t32}, 32'd0);
    check("reset_display16", d16, 32'd0);

    repeat (300) send_byte(1'b1, 1'b1);
    send_byte(1'b0, 1'b1);
    repeat (50) send_byte(1'b1, 1'b1);
    do_reset();
    check("midframe_reset_display", d32, 32'd0);

    send_frame(4, 640, 640); idle(3);
    check("frame1_stable", {31'd0, s32}, {31'd0, exp_stable});
    send_frame(4, 640, 640); idle(3);
    check("frame2_stable", {31'd0, s32}, {31'd0, exp_stable});
    send_frame(4, 640, 640); idle(3);
    check("frame3_stable", {31'd0, s32}, {31'd0, exp_stable});
    check("mode2_lines_rowlen", d32, {exp_lines[15:0], exp_rowlen[15:0]});
    mode_in = 2'd1;
    step();
    check("mode1_framelen", d32, exp_flen);
    check("mode1_framelen16", d16, exp_flen);

    do_clear();
    mode_in = 2'd0;
    gap_max = 1;
    for (int k = 0; k < 5; k++) begin
      int len;
      len = $urandom_range(3, 10);
      send_frame(1, len, len);
    end
    fps_first = frames_sent;
    gap_max = 0;
    while (since_clr < 994) idle(1);
    repeat (5) send_byte(1'b1, 1'b1);
    check("tick_before", {31'd0, t32}, 32'd0);
    send_byte(1'b1, 1'b1);
    check("tick_on", {31'd0, t32}, 32'd1);
    check("tick_on16", {31'd0, t16}, 32'd1);
    bytes_first = bytes_sent;
    send_byte(1'b0, 1'b0);
    check("tick_after", {31'd0, t32}, 32'd0);
    idle(3);
    check("fps_first_second", d32, {fps_first[15:0], 16'd6});
    mode_in = 2'd3;
    step();
    check("bps_first_second", d32, bytes_first);
    while (since_clr < 2004) idle(1);
    check("bps_second_second", d32, bytes_sent - bytes_first);
    mode_in = 2'd0;
    step();
    check("fps_second_second", d32, {16'd1, 16'd6});

    do_clear();
    gap_max = 1;
    mode_in = 2'd2;
    begin
      int base;
      base = $urandom_range(8, 20);
      for (int k = 0; k < 3; k++) begin
        send_frame(4, base, base + 1); idle(2);
        check("alternating_stable", {31'd0, s32}, {31'd0, exp_stable});
      end
    end
    for (int k = 0; k < 4; k++) begin
      int n, a, b;
      n = $urandom_range(1, 5);
      a = $urandom_range(4, 16);
      b = a + int'($urandom_range(0, 1));
      mode_in = 2'd2;
      send_frame(n, a, b); idle(2);
      check("rand_stable", {31'd0, s32}, {31'd0, exp_stable});
      check("rand_mode2", d32, {exp_lines[15:0], exp_rowlen[15:0]});
      mode_in = 2'd1;
      step();
      check("rand_mode1", d32, exp_flen);
    end
    mode_in = 2'd2;
    begin
      int n, a;
      n = $urandom_range(2, 5);
      a = $urandom_range(4, 16);
      for (int k = 0; k < 3; k++) begin
        send_frame(n, a, a); idle(2);
        check("steady_stable", {31'd0, s32}, {31'd0, exp_stable});
      end
    end

    gap_max = 0;
    repeat (7) send_byte(1'b1, 1'b1);
    valid_byte_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1; clear_in = 1'b1;
    step();
    valid_byte_in = 1'b0; clear_in = 1'b0;
    model_zero();
    check("clear_display", d32, 32'd0);
    check("clear_stable", {31'd0, s32}, 32'd0);
    check("clear_tick", {31'd0, t32}, 32'd0);
    check("clear_display16", d16, 32'd0);
    mode_in = 2'd0;
    idle(2);
    check("clear_beats_hfall", d32, 32'd0);

    nsat = 65540;
    exp_sat16 = (nsat > 65535) ? 65535 : nsat;
    repeat (nsat) send_byte(1'b1, 1'b1);
    send_byte(1'b0, 1'b0);
    idle(3);
    check("sat_rowlen16", {16'd0, d16[15:0]}, exp_sat16);
    check("rowlen32_low", {16'd0, d32[15:0]}, nsat & 32'hFFFF);
    mode_in = 2'd1;
    step();
    check("sat_framelen16", d16, exp_sat16);
    check("framelen32", d32, nsat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
